// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester arbiter and start/8-data/stop frame sequencer with a bit-rate divider.
// Define UART_TX_SCHED_RR_EN for round-robin arbitration; otherwise req0 always wins (fixed priority).
module uart_tx_sched #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic [7:0] tx_ctrl,
    output logic       tx_bit_en,
    output logic       busy,
    output logic [1:0] grant
);
    localparam int DW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          stop_cnt_q, stop_cnt_d;
    logic [7:0]    tx_data_q, tx_data_d, tx_ctrl_q, tx_ctrl_d;
    logic [1:0]    grant_q, grant_d;
    logic          tick, arb, pick0, pick1;
`ifdef UART_TX_SCHED_RR_EN
    logic          rr_q, rr_d;
`endif
    assign tick = div_q == DW'(CLKS_PER_BIT - 1);
    assign arb  = tick && (state_q == IDLE || (state_q == STOP && stop_cnt_q == 1'(STOP_BITS - 1)));
`ifdef UART_TX_SCHED_RR_EN
    // rr_q set means req1 is preferred when both requesters are valid
    assign pick0 = req0_valid && !(req1_valid && rr_q);
`else
    assign pick0 = req0_valid;
`endif
    assign pick1      = req1_valid && !pick0;
    assign req0_ready = arb && pick0;
    assign req1_ready = arb && pick1;
    assign tx_bit_en  = tick;
    assign tx_data    = tx_data_q;
    assign tx_ctrl    = tx_ctrl_q;
    assign grant      = grant_q;
    assign busy       = state_q != IDLE;
    // next-state: free-running divider, frame sequencing and arbitration on tick boundaries
    always_comb begin
        div_d      = tick ? '0 : div_q + 1'b1;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_data_d  = tx_data_q;
        tx_ctrl_d  = tx_ctrl_q;
        grant_d    = grant_q;
`ifdef UART_TX_SCHED_RR_EN
        rr_d       = rr_q;
`endif
        if (arb) begin
            state_d   = (pick0 || pick1) ? START : IDLE;
            tx_ctrl_d = (pick0 || pick1) ? 8'h01 : 8'h00;
            grant_d   = {pick1, pick0};
            tx_data_d = pick0 ? req0_data : pick1 ? req1_data : tx_data_q;
`ifdef UART_TX_SCHED_RR_EN
            rr_d      = (pick0 || pick1) ? pick0 : rr_q;
`endif
        end else if (tick) begin
            case (state_q)
                START: begin
                    state_d   = DATA;
                    tx_ctrl_d = 8'h02;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d    = STOP;
                        tx_ctrl_d  = 8'h00;
                        stop_cnt_d = 1'b0;
                    end
                end
                STOP:    stop_cnt_d = stop_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end
    // state registers; reset drops any in-flight frame and idles the line
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_ctrl_q  <= 8'h00;
            grant_q    <= 2'b00;
`ifdef UART_TX_SCHED_RR_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_ctrl_q  <= tx_ctrl_d;
            grant_q    <= grant_d;
`ifdef UART_TX_SCHED_RR_EN
            rr_q       <= rr_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and random checks of uart_tx_sched against a frame-timing reference model.
module tb_uart_tx_sched;
    localparam int C = 4;
    localparam int L = 10 * C;
`ifdef UART_TX_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic       clk = 1'b0, resetn = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready, tx_bit_en, busy;
    logic [7:0] tx_data, tx_ctrl;
    logic [1:0] grant;
    logic       b_valid = 1'b0, b_r1_valid = 1'b0;
    logic [7:0] b_data = 8'h00, b_r1_data = 8'h00;
    logic       b_ready, b_r1_ready, b_bit_en, b_busy;
    logic [7:0] b_tx_data, b_tx_ctrl;
    logic [1:0] b_grant;
    int         n_assert = 0, n_fail = 0;
    int         k, m_s, m_last, obs_k;
    bit         m_busy, acc0, acc1, b_acc, o_busy, b_bsy;
    logic [7:0] m_data, o_ctrl, b_ctl, b_dat;
    logic [1:0] m_grant;

    always #5 clk = ~clk;

    uart_tx_sched #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_ctrl(tx_ctrl), .tx_bit_en(tx_bit_en), .busy(busy), .grant(grant)
    );

    uart_tx_sched #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut_b (
        .clk(clk), .resetn(resetn),
        .req0_valid(b_valid), .req0_data(b_data), .req0_ready(b_ready),
        .req1_valid(b_r1_valid), .req1_data(b_r1_data), .req1_ready(b_r1_ready),
        .tx_data(b_tx_data), .tx_ctrl(b_tx_ctrl), .tx_bit_en(b_bit_en), .busy(b_busy), .grant(b_grant)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    task automatic m_reset();
        k = 0; m_s = -1000; m_busy = 1'b0; m_data = 8'h00; m_grant = 2'b00; m_last = 1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready0"}, 32'(req0_ready), 0);
        chk({tag, "_ready1"}, 32'(req1_ready), 0);
        chk({tag, "_ctrl"},   32'(tx_ctrl), 0);
        chk({tag, "_data"},   32'(tx_data), 0);
        chk({tag, "_grant"},  32'(grant), 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_bit_en"}, 32'(tx_bit_en), 0);
        chk({tag, "_b_ctrl"}, 32'(b_tx_ctrl), 0);
    endtask

    // One clock cycle: compare against the model mid-cycle, then advance the model
    task automatic step();
        int off, w;
        bit tk, arb;
        logic [7:0] ectl;
        @(negedge clk);
        tk  = (k % C) == C - 1;
        arb = tk && (!m_busy || k == m_s + L - 1);
        w   = -1;
        if (arb) begin
            if (req0_valid && req1_valid) w = (RR && m_last == 0) ? 1 : 0;
            else if (req0_valid) w = 0;
            else if (req1_valid) w = 1;
        end
        off  = k - m_s;
        ectl = !m_busy ? 8'h00 : off < C ? 8'h01 : off < 9 * C ? 8'h02 : 8'h00;
        chk("bit_en", 32'(tx_bit_en), 32'(tk));
        chk("ready0", 32'(req0_ready), 32'(w == 0));
        chk("ready1", 32'(req1_ready), 32'(w == 1));
        chk("ctrl",   32'(tx_ctrl), 32'(ectl));
        chk("data",   32'(tx_data), 32'(m_data));
        chk("grant",  32'(grant), 32'(m_busy ? m_grant : 2'b00));
        chk("busy",   32'(busy), 32'(m_busy));
        acc0 = req0_ready; acc1 = req1_ready; o_busy = busy; o_ctrl = tx_ctrl;
        b_acc = b_ready; b_bsy = b_busy; b_ctl = b_tx_ctrl; b_dat = b_tx_data;
        if (req0_ready || req1_ready) obs_k = k;
        if (arb) begin
            if (w >= 0) begin
                m_busy = 1'b1; m_s = k + 1; m_last = w;
                m_data = (w == 0) ? req0_data : req1_data;
                m_grant = (w == 0) ? 2'b01 : 2'b10;
            end else m_busy = 1'b0;
        end
        k++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input string tag);
        int n = 0;
        do begin step(); n++; end while (!(acc0 || acc1) && n < 2 * L);
        chk({tag, "_accept_seen"}, 32'(acc0 || acc1), 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset(input string tag);
        resetn = 1'b1;
        #1;
        chk_reset(tag);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        m_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k1, k2, c1, c2, cb, n, z;
        int g[4];
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        resetn = 1'b0;
        // single byte
        req0_valid = 1'b1; req0_data = 8'hA5;
        wait_acc("single");
        chk("single_accept_on_tick", 32'(obs_k % C), C - 1);
        chk("single_ready0", 32'(acc0), 1);
        req0_valid = 1'b0; req0_data = 8'h00;
        c1 = 0; c2 = 0; cb = 0;
        for (int i = 0; i < L + C; i++) begin
            step();
            c1 += int'(o_ctrl == 8'h01); c2 += int'(o_ctrl == 8'h02); cb += int'(o_busy);
        end
        chk("single_ctrl01_len", 32'(c1), 4);
        chk("single_ctrl02_len", 32'(c2), 32);
        chk("single_busy_len", 32'(cb), 40);
        // back-to-back from one requester
        req0_valid = 1'b1; req0_data = 8'h11;
        wait_acc("b2b_first");
        k1 = obs_k;
        req0_data = 8'h22;
        wait_acc("b2b_second");
        k2 = obs_k;
        req0_valid = 1'b0;
        chk("b2b_spacing", 32'(k2 - k1), 40);
        step();
        chk("b2b_no_idle_gap", 32'(o_busy), 1);
        idle(L + C);
        // contention with fresh pointer
        pulse_reset("pre_contention");
        req0_valid = 1'b1; req0_data = 8'h01;
        req1_valid = 1'b1; req1_data = 8'h02;
        for (int i = 0; i < 4; i++) begin
            wait_acc("contention");
            g[i] = acc1 ? 2 : 1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) chk("contention_winner", 32'(g[i]), (RR && i % 2 == 1) ? 2 : 1);
        idle(L + C);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = $urandom_range(0, 3) == 0; req0_data = 8'($urandom);
            req1_valid = $urandom_range(0, 2) == 0; req1_data = 8'($urandom);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle(L + C);
        // reset during DATA with bit_cnt = 3
        req0_valid = 1'b1; req0_data = 8'h5A;
        wait_acc("mid_frame");
        req0_valid = 1'b0;
        n = 0;
        while (!(m_busy && k - m_s == 4 * C + 1) && n < 2 * L) begin step(); n++; end
        chk("mid_frame_in_data", 32'(o_ctrl), 8'h02);
        pulse_reset("mid_reset");
        req1_valid = 1'b1; req1_data = 8'h3C;
        wait_acc("after_reset");
        chk("after_reset_accept_cycle", 32'(obs_k), C - 1);
        chk("after_reset_ready1", 32'(acc1), 1);
        req1_valid = 1'b0;
        idle(L + C);
        // two stop bits on the second instance
        b_valid = 1'b1; b_data = 8'hFF;
        n = 0;
        do begin step(); n++; end while (!b_acc && n < 2 * L);
        chk("sb2_accept_seen", 32'(b_acc), 1);
        b_valid = 1'b0;
        n = 0; z = 0;
        step();
        while (b_bsy && n < 100) begin
            n++;
            z += int'(b_ctl == 8'h00);
            chk("sb2_data", 32'(b_dat), 8'hFF);
            step();
        end
        chk("sb2_frame_len", 32'(n), 44);
        chk("sb2_stop_len", 32'(z), 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
